// File: rtl/cache_line_fill_engine.sv
// Read-miss line-fill engine: issues one L2 word read per line word and returns a registered cache entry.
// Optional critical-word-first / early restart is enabled by defining CACHE_FILL_CRIT_WORD_FIRST_EN.
module cache_line_fill_engine #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 8,
   parameter int TAG_W          = 18,
   parameter int MAX_OUT        = 4,
   localparam int BO      = $clog2(DATA_W / 8),
   localparam int WO      = $clog2(WORDS_PER_LINE),
   localparam int IDX_W   = ADDR_W - TAG_W - BO - WO,
   localparam int ENTRY_W = 1 + TAG_W + DATA_W * WORDS_PER_LINE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               miss_valid,
   output logic               miss_ready,
   input  logic [ADDR_W-1:0]  miss_addr,
   input  logic               abort,
   output logic               l2_req_valid,
   input  logic               l2_req_ready,
   output logic [ADDR_W-1:0]  l2_req_addr,
   input  logic               l2_rsp_valid,
   input  logic [DATA_W-1:0]  l2_rsp_data,
   output logic               upd_entry,
   output logic [IDX_W-1:0]   upd_index,
   output logic [ENTRY_W-1:0] entry_upd_val,
   output logic               crit_valid,
   output logic [DATA_W-1:0]  crit_data,
   output logic               busy
);

   localparam int LA_W = ADDR_W - BO - WO;
   localparam logic [WO:0] N_C    = (WO + 1)'(WORDS_PER_LINE);
   localparam logic [WO:0] LAST_C = N_C - 1'b1;
   localparam logic [WO:0] MAX_C  = (WO + 1)'(MAX_OUT);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

   state_t                            state, state_nxt;
   logic [LA_W-1:0]                   line_addr;
   logic [WO-1:0]                     start, miss_start;
   logic [WO:0]                       req_cnt, rsp_cnt, out_cnt, out_nxt;
   logic [WO-1:0]                     req_idx, rsp_idx;
   logic [WORDS_PER_LINE-1:0][DATA_W-1:0] line_buf, buf_nxt;
   logic                              req_fire, rsp_fire;
   logic                              unused_bits;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
   assign miss_start = miss_addr[BO +: WO];
`else
   assign miss_start = '0;
`endif
   assign unused_bits = ^miss_addr[BO+WO-1:0];

   assign out_cnt      = req_cnt - rsp_cnt;
   assign req_idx      = start + req_cnt[WO-1:0];
   assign rsp_idx      = start + rsp_cnt[WO-1:0];
   assign l2_req_valid = (state == S_REQ) && (req_cnt < N_C) && (out_cnt < MAX_C);
   assign req_fire     = l2_req_valid && l2_req_ready;
   assign rsp_fire     = l2_rsp_valid && (out_cnt != '0);
   assign out_nxt      = out_cnt + (WO + 1)'(req_fire) - (WO + 1)'(rsp_fire);
   assign l2_req_addr  = ADDR_W'({line_addr, req_idx}) << BO;
   assign miss_ready   = (state == S_IDLE);
   assign busy         = (state != S_IDLE);
   assign upd_entry    = (state == S_DONE);

   always_comb begin
      buf_nxt = line_buf;
      if (rsp_fire) buf_nxt[rsp_idx] = l2_rsp_data;
   end

   // An abort that leaves nothing in flight skips DRAIN and returns to IDLE directly.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (miss_valid) state_nxt = S_REQ;
         S_REQ: begin
            if (abort)                                state_nxt = (out_nxt == '0) ? S_IDLE : S_DRAIN;
            else if (req_fire && (req_cnt == LAST_C)) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (abort)                                state_nxt = (out_nxt == '0) ? S_IDLE : S_DRAIN;
            else if (rsp_fire && (rsp_cnt == LAST_C)) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         S_DRAIN: if (out_nxt == '0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         line_addr     <= '0;
         start         <= '0;
         req_cnt       <= '0;
         rsp_cnt       <= '0;
         line_buf      <= '0;
         entry_upd_val <= '0;
         upd_index     <= '0;
      end else begin
         state    <= state_nxt;
         line_buf <= buf_nxt;
         if ((state == S_IDLE) && miss_valid) begin
            line_addr <= miss_addr[ADDR_W-1 -: LA_W];
            start     <= miss_start;
            req_cnt   <= '0;
            rsp_cnt   <= '0;
         end else begin
            if (req_fire) req_cnt <= req_cnt + 1'b1;
            if (rsp_fire) rsp_cnt <= rsp_cnt + 1'b1;
         end
         // Entry is built from buf_nxt so the final word lands in the same edge.
         if ((state == S_WAIT) && (state_nxt == S_DONE)) begin
            entry_upd_val <= {1'b1, line_addr[LA_W-1 -: TAG_W], buf_nxt};
            upd_index     <= line_addr[IDX_W-1:0];
         end
      end
   end

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
   logic first_rsp;
   assign first_rsp = rsp_fire && (rsp_cnt == '0) && ((state == S_REQ) || (state == S_WAIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crit_valid <= 1'b0;
         crit_data  <= '0;
      end else begin
         crit_valid <= first_rsp;
         if (first_rsp) crit_data <= l2_rsp_data;
      end
   end
`else
   assign crit_valid = 1'b0;
   assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_cache_line_fill_engine.sv
// Directed bench for cache_line_fill_engine with a behavioural in-order L2 returning data = word address.
module tb_cache_line_fill_engine;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int N       = 8;
   localparam int TAG_W   = 18;
   localparam int IDX_W   = 9;
   localparam int ENTRY_W = 275;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               miss_valid = 1'b0;
   logic               miss_ready;
   logic [ADDR_W-1:0]  miss_addr = '0;
   logic               abort = 1'b0;
   logic               l2_req_valid;
   logic               l2_req_ready;
   logic [ADDR_W-1:0]  l2_req_addr;
   logic               l2_rsp_valid;
   logic [DATA_W-1:0]  l2_rsp_data;
   logic               upd_entry;
   logic [IDX_W-1:0]   upd_index;
   logic [ENTRY_W-1:0] entry_upd_val;
   logic               crit_valid;
   logic [DATA_W-1:0]  crit_data;
   logic               busy;

   cache_line_fill_engine #(.MAX_OUT(2)) dut (
      .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready),
      .miss_addr(miss_addr), .abort(abort), .l2_req_valid(l2_req_valid),
      .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
      .l2_rsp_valid(l2_rsp_valid), .l2_rsp_data(l2_rsp_data),
      .upd_entry(upd_entry), .upd_index(upd_index), .entry_upd_val(entry_upd_val),
      .crit_valid(crit_valid), .crit_data(crit_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct { int due; logic [31:0] data; } pend_t;
   pend_t       pend[$];
   logic [31:0] req_log[$];
   int lat = 1, rsp_limit = 1000000;
   bit ready_toggle = 1'b0;
   int issued, delivered, max_out, first_req_cyc, first_rsp_cyc, last_rsp_cyc;
   int upd_count, crit_count, crit_cyc;
   logic [31:0] crit_seen;

   // L2: in-order, fixed latency, optional ready toggling and response throttling.
   initial begin
      l2_req_ready = 1'b0; l2_rsp_valid = 1'b0; l2_rsp_data = '0;
      forever begin
         @(negedge clk);
         if (!rst && pend.size() > 0 && pend[0].due <= cyc && delivered < rsp_limit) begin
            l2_rsp_valid = 1'b1;
            l2_rsp_data  = pend[0].data;
            void'(pend.pop_front());
            delivered++;
            if (delivered == 1) first_rsp_cyc = cyc;
            last_rsp_cyc = cyc;
         end else begin
            l2_rsp_valid = 1'b0;
         end
         l2_req_ready = ready_toggle ? (cyc % 2 == 0) : 1'b1;
         if (l2_req_valid && l2_req_ready) begin
            pend.push_back('{cyc + lat, l2_req_addr});
            req_log.push_back(l2_req_addr);
            if (issued == 0) first_req_cyc = cyc;
            issued++;
         end
         if (issued - delivered > max_out) max_out = issued - delivered;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (upd_entry) upd_count++;
         if (crit_valid) begin crit_count++; crit_cyc = cyc; crit_seen = crit_data; end
      end
   end

   function automatic logic [ENTRY_W-1:0] exp_entry(input logic [31:0] a);
      logic [ENTRY_W-1:0] e;
      logic [31:0] base;
      base = a & 32'hFFFF_FFE0;
      e = '0;
      e[ENTRY_W-1] = 1'b1;
      e[ENTRY_W-2 -: TAG_W] = a[31 -: TAG_W];
      for (int j = 0; j < N; j++) e[j*32 +: 32] = base + 32'(4 * j);
      return e;
   endfunction

   function automatic logic [31:0] exp_req(input logic [31:0] a, input int i);
      int off;
      off = CWF ? int'(a[4:2]) : 0;
      return (a & 32'hFFFF_FFE0) + 32'(4 * ((off + i) % N));
   endfunction

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic start_fill(input logic [31:0] a, output int t);
      pend.delete(); req_log.delete();
      issued = 0; delivered = 0; max_out = 0;
      first_req_cyc = -1; first_rsp_cyc = -1; last_rsp_cyc = -1;
      upd_count = 0; crit_count = 0; crit_cyc = -1; crit_seen = '0;
      miss_addr = a; miss_valid = 1'b1; t = cyc;
      tick();
      miss_valid = 1'b0;
   endtask

   task automatic wait_upd(output int u);
      u = -1;
      for (int k = 0; k < 100; k++) begin
         if (upd_entry) begin u = cyc; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      tick();
      checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL rst_miss_ready got=%b exp=1", miss_ready); end
      checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", l2_req_valid); end
      checks++; if (upd_entry !== 1'b0) begin failures++; $display("FAIL rst_upd_entry got=%b exp=0", upd_entry); end
      checks++; if (crit_valid !== 1'b0) begin failures++; $display("FAIL rst_crit_valid got=%b exp=0", crit_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (entry_upd_val !== '0) begin failures++; $display("FAIL rst_entry got=%h exp=0", entry_upd_val); end
      checks++; if (upd_index !== '0) begin failures++; $display("FAIL rst_index got=%h exp=0", upd_index); end
      checks++; if (l2_req_addr !== '0) begin failures++; $display("FAIL rst_req_addr got=%h exp=0", l2_req_addr); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [31:0] a;
      int t, u, bad;
      a = 32'h0000_1234; lat = 1; ready_toggle = 1'b0; rsp_limit = 1000000;
      start_fill(a, t);
      wait_upd(u);
      checks++; if (u !== t + 10) begin failures++; $display("FAIL basic_upd_cycle got=%0d exp=%0d", u - t, 10); end
      checks++; if (first_req_cyc !== t + 1) begin failures++; $display("FAIL basic_first_req got=%0d exp=%0d", first_req_cyc - t, 1); end
      checks++; if (entry_upd_val !== exp_entry(a)) begin failures++; $display("FAIL basic_entry got=%h exp=%h", entry_upd_val, exp_entry(a)); end
      checks++; if (upd_index !== 9'h091) begin failures++; $display("FAIL basic_index got=%h exp=091", upd_index); end
      checks++; if (req_log.size() !== N) begin failures++; $display("FAIL basic_req_count got=%0d exp=%0d", req_log.size(), N); end
      bad = -1;
      for (int i = 0; i < N && i < req_log.size(); i++) if (bad < 0 && req_log[i] !== exp_req(a, i)) bad = i;
      checks++; if (bad >= 0) begin failures++; $display("FAIL basic_req_addr[%0d] got=%h exp=%h", bad, req_log[bad], exp_req(a, bad)); end
      tick();
      checks++; if (upd_entry !== 1'b0 || miss_ready !== 1'b1) begin failures++; $display("FAIL basic_after_done got upd=%b ready=%b exp upd=0 ready=1", upd_entry, miss_ready); end
      checks++; if (upd_count !== 1) begin failures++; $display("FAIL basic_upd_pulses got=%0d exp=1", upd_count); end
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
      checks++; if (crit_count !== 1) begin failures++; $display("FAIL crit_pulses got=%0d exp=1", crit_count); end
      checks++; if (crit_cyc !== first_rsp_cyc + 1) begin failures++; $display("FAIL crit_cycle got=%0d exp=%0d", crit_cyc, first_rsp_cyc + 1); end
      checks++; if (crit_seen !== 32'h0000_1234) begin failures++; $display("FAIL crit_data got=%h exp=00001234", crit_seen); end
`else
      checks++; if (crit_count !== 0 || crit_data !== '0) begin failures++; $display("FAIL crit_off got pulses=%0d data=%h exp 0/0", crit_count, crit_data); end
`endif
   endtask

   task automatic test_backpressure();
      logic [31:0] a;
      int t, u, bad;
      a = 32'h0003_8A48; lat = 5; ready_toggle = 1'b1; rsp_limit = 1000000;
      start_fill(a, t);
      wait_upd(u);
      checks++; if (u < 0) begin failures++; $display("FAIL bp_upd_timeout got=none exp=pulse"); end
      checks++; if (max_out > 2) begin failures++; $display("FAIL bp_outstanding got=%0d exp<=2", max_out); end
      checks++; if (entry_upd_val !== exp_entry(a)) begin failures++; $display("FAIL bp_entry got=%h exp=%h", entry_upd_val, exp_entry(a)); end
      checks++; if (upd_index !== a[13:5]) begin failures++; $display("FAIL bp_index got=%h exp=%h", upd_index, a[13:5]); end
      bad = (req_log.size() == N) ? -1 : N;
      for (int i = 0; i < N && i < req_log.size(); i++) if (bad < 0 && req_log[i] !== exp_req(a, i)) bad = i;
      checks++; if (bad >= 0) begin failures++; $display("FAIL bp_req_order idx=%0d count=%0d exp count=%0d", bad, req_log.size(), N); end
      for (int k = 0; k < 4; k++) tick();
      checks++; if (upd_count !== 1) begin failures++; $display("FAIL bp_upd_pulses got=%0d exp=1", upd_count); end
      ready_toggle = 1'b0;
   endtask

   task automatic test_abort_drain();
      int t, found, mr_cyc;
      lat = 1; ready_toggle = 1'b0; rsp_limit = 3;
      start_fill(32'h0000_5000, t);
      found = 0;
      for (int k = 0; k < 50; k++) begin
         if (issued == 5 && delivered == 3) begin found = 1; break; end
         tick();
      end
      checks++; if (found !== 1) begin failures++; $display("FAIL drain_setup_timeout got issued=%0d rsp=%0d exp 5/3", issued, delivered); end
      abort = 1'b1; rsp_limit = 1000000;
      tick();
      abort = 1'b0;
      mr_cyc = -1;
      for (int k = 0; k < 20; k++) begin
         if (miss_ready && mr_cyc < 0) mr_cyc = cyc;
         tick();
      end
      checks++; if (issued !== 5) begin failures++; $display("FAIL drain_no_new_req got=%0d exp=5", issued); end
      checks++; if (delivered !== 5) begin failures++; $display("FAIL drain_rsp_consumed got=%0d exp=5", delivered); end
      checks++; if (upd_count !== 0) begin failures++; $display("FAIL drain_no_upd got=%0d exp=0", upd_count); end
      checks++; if (mr_cyc <= last_rsp_cyc || mr_cyc > last_rsp_cyc + 2) begin failures++; $display("FAIL drain_ready_cycle got=%0d exp in (%0d,%0d]", mr_cyc, last_rsp_cyc, last_rsp_cyc + 2); end
      checks++; if (entry_upd_val !== exp_entry(32'h0003_8A48)) begin failures++; $display("FAIL drain_entry_hold got=%h exp=%h", entry_upd_val, exp_entry(32'h0003_8A48)); end
   endtask

   task automatic test_abort_last();
      int t, r;
      lat = 1; ready_toggle = 1'b0; rsp_limit = 1000000;
      start_fill(32'h0000_6000, t);
      r = -1;
      for (int k = 0; k < 50; k++) begin
         if (l2_rsp_valid && delivered == 8) begin r = cyc; break; end
         tick();
      end
      checks++; if (r < 0) begin failures++; $display("FAIL abort_last_timeout got=none exp=8th response"); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (miss_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_last_idle got ready=%b busy=%b exp 1/0", miss_ready, busy); end
      for (int k = 0; k < 3; k++) tick();
      checks++; if (upd_count !== 0) begin failures++; $display("FAIL abort_last_no_upd got=%0d exp=0", upd_count); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] a;
      int t, u, bad;
      lat = 4; ready_toggle = 1'b0; rsp_limit = 1000000;
      start_fill(32'h0000_7000, t);
      for (int k = 0; k < 20; k++) begin
         if (issued == 2) break;
         tick();
      end
      rsp_limit = delivered;
      rst = 1'b1;
      #1;
      checks++; if (miss_ready !== 1'b1 || busy !== 1'b0 || l2_req_valid !== 1'b0 || upd_entry !== 1'b0)
         begin failures++; $display("FAIL midrst_ctrl got ready=%b busy=%b req=%b upd=%b exp 1/0/0/0", miss_ready, busy, l2_req_valid, upd_entry); end
      checks++; if (entry_upd_val !== '0 || upd_index !== '0 || l2_req_addr !== '0)
         begin failures++; $display("FAIL midrst_data got entry=%h idx=%h addr=%h exp 0", entry_upd_val, upd_index, l2_req_addr); end
      tick();
      rst = 1'b0;
      rsp_limit = delivered + 2;
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         if (!miss_ready || busy || upd_entry) bad = 1;
         tick();
      end
      checks++; if (delivered !== 2) begin failures++; $display("FAIL stale_delivered got=%0d exp=2", delivered); end
      checks++; if (bad !== 0 || crit_count !== 0) begin failures++; $display("FAIL stale_ignored got bad=%0d crit=%0d exp 0/0", bad, crit_count); end
      a = 32'h0000_8A64; lat = 1; rsp_limit = 1000000;
      start_fill(a, t);
      wait_upd(u);
      checks++; if (u !== t + 10) begin failures++; $display("FAIL refill_upd_cycle got=%0d exp=10", u - t); end
      checks++; if (entry_upd_val !== exp_entry(a)) begin failures++; $display("FAIL refill_entry got=%h exp=%h", entry_upd_val, exp_entry(a)); end
      checks++; if (upd_index !== 9'h053) begin failures++; $display("FAIL refill_index got=%h exp=053", upd_index); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_abort_drain();
      test_abort_last();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=hang exp=finish");
      $fatal(1);
   end

endmodule
